// File: rtl/adder_result_fifo.sv
// adder_result_fifo
//   Capture stage behind the registered WIDTH-bit adder. It samples the
//   (WIDTH+1)-bit sum whenever sum_valid is high. The sum is buffered in a
//   DEPTH-entry first-word-fall-through FIFO, and buffered results drain
//   through a valid/ready output. The stage also keeps a sticky overflow flag
//   and a saturating count of accepted sums that carried out (MSB set).
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   sum_in       adder result, WIDTH+1 bits
//   sum_valid    capture sum_in this cycle
//   out_data     head-of-FIFO entry (0 while empty)
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts out_data this cycle
//   count        entries stored, 0..DEPTH
//   full, empty  count==DEPTH / count==0
//   overflow     sticky, a sum was dropped because the FIFO was full
//   carry_count  accepted sums with MSB set, saturating at 255
//   clear_stats  synchronous clear of overflow and carry_count
module adder_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH:0]           sum_in,
  input  logic                     sum_valid,
  output logic [WIDTH:0]           out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               carry_count,
  input  logic                     clear_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = WIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    CARRY_MAX = 8'd255;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r, empty_r, valid_r, overflow_r;
  logic [DW-1:0] data_r;
  logic [7:0]    carry_r;

  logic          push_s, pop_s, drop_s, counted_s;
  logic [AW-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [DW-1:0] data_nxt_s;
  logic          overflow_nxt_s;
  logic [7:0]    carry_nxt_s;

  // Handshake decode, next pointer and count values, and the next registered head.
  always_comb begin
    pop_s     = valid_r & out_ready;
    // A full FIFO that is popping this cycle still has room for a push.
    push_s    = sum_valid & (~full_r | out_ready);
    drop_s    = sum_valid & full_r & ~out_ready;
    counted_s = push_s & sum_in[WIDTH];

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase

    // The head slot may be the slot being written this cycle. That happens
    // when the FIFO is empty, or becomes empty, while a push lands.
    if (count_nxt_s == CW'(0)) begin
      data_nxt_s = '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      data_nxt_s = sum_in;
    end else begin
      data_nxt_s = mem_r[rd_ptr_nxt_s];
    end

    // A drop wins over a same-cycle clear.
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (clear_stats) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end

    if (clear_stats) begin
      carry_nxt_s = counted_s ? 8'd1 : 8'd0;
    end else if (counted_s && (carry_r != CARRY_MAX)) begin
      carry_nxt_s = carry_r + 8'd1;
    end else begin
      carry_nxt_s = carry_r;
    end
  end

  // Storage array, intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= sum_in;
    end
  end

  // Pointers, occupancy, registered outputs and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      valid_r    <= 1'b0;
      data_r     <= '0;
      overflow_r <= 1'b0;
      carry_r    <= 8'd0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == FULL_CNT);
      empty_r    <= (count_nxt_s == CW'(0));
      valid_r    <= (count_nxt_s != CW'(0));
      data_r     <= data_nxt_s;
      overflow_r <= overflow_nxt_s;
      carry_r    <= carry_nxt_s;
    end
  end

  assign out_data    = data_r;
  assign out_valid   = valid_r;
  assign count       = count_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign overflow    = overflow_r;
  assign carry_count = carry_r;

endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] sum_in = 9'h000;
  logic       sum_valid = 1'b0;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       full, empty, overflow;
  logic [7:0] carry_count;
  logic       clear_stats = 1'b0;

  int total = 0;
  int bad = 0;

  adder_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .carry_count(carry_count), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle 1ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (out_data !== 9'h000) begin bad++; $display("FAIL reset_data got=%h exp=000", out_data); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0 || carry_count !== 8'd0) begin bad++; $display("FAIL reset_stats got=%0b/%0d exp=0/0", overflow, carry_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_capture();
    step();
    sum_in = 9'h0FF; sum_valid = 1'b1; out_ready = 1'b0;
    step();
    sum_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 9'h0FF) begin bad++; $display("FAIL single_data got=%h exp=0ff", out_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    total++; if (carry_count !== 8'd0) begin bad++; $display("FAIL single_carry got=%0d exp=0", carry_count); end
    step();
    total++; if (out_data !== 9'h0FF) begin bad++; $display("FAIL single_hold got=%h exp=0ff", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (empty !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=e%0b c%0d v%0b exp=e1 c0 v0", empty, count, out_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [8:0] vals [4];
    vals[0] = 9'h100; vals[1] = 9'h001; vals[2] = 9'h1FE; vals[3] = 9'h042;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum_in = vals[i]; sum_valid = 1'b1;
      step();
    end
    sum_valid = 1'b0;
    total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL fill_full got=f%0b c%0d exp=f1 c4", full, count); end
    total++; if (carry_count !== 8'd2) begin bad++; $display("FAIL fill_carry got=%0d exp=2", carry_count); end
    total++; if (out_data !== 9'h100) begin bad++; $display("FAIL fill_head got=%h exp=100", out_data); end
    sum_in = 9'h055; sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    total++; if (overflow !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL drop got=o%0b c%0d exp=o1 c4", overflow, count); end
    total++; if (out_data !== 9'h100 || carry_count !== 8'd2) begin bad++; $display("FAIL drop_head got=%h/%0d exp=100/2", out_data, carry_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin bad++; $display("FAIL drain%0d got=%h v%0b exp=%h", i, out_data, out_valid, vals[i]); end
      step();
    end
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    total++; if (overflow !== 1'b0 || carry_count !== 8'd0) begin bad++; $display("FAIL clear1 got=%0b/%0d exp=0/0", overflow, carry_count); end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] exp_q [4];
    exp_q[0] = 9'h0A2; exp_q[1] = 9'h0A3; exp_q[2] = 9'h0A4; exp_q[3] = 9'h1AA;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sum_in = 9'h0A0 + 9'(i); sum_valid = 1'b1;
      step();
    end
    sum_in = 9'h1AA; sum_valid = 1'b1; out_ready = 1'b1;
    step();
    sum_valid = 1'b0;
    total++; if (overflow !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL fullpp got=o%0b c%0d exp=o0 c4", overflow, count); end
    total++; if (carry_count !== 8'd1) begin bad++; $display("FAIL fullpp_carry got=%0d exp=1", carry_count); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin bad++; $display("FAIL fullpp_drain%0d got=%h exp=%h", i, out_data, exp_q[i]); end
      step();
    end
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullpp_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sum_in = 9'(i); sum_valid = 1'b1;
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 9'(i) || count > 3'd1) begin bad++; $display("FAIL stream%0d got=%h c%0d exp=%h c<=1", i, out_data, count, 9'(i)); end
    end
    sum_valid = 1'b0;
    step();
    out_ready = 1'b0;
    total++; if (empty !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL stream_end got=e%0b o%0b exp=e1 o0", empty, overflow); end
  endtask

  task automatic test_statistics();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sum_in = {1'b1, 8'(i)}; sum_valid = 1'b1;
      step();
      if (i == 253) begin
        total++; if (carry_count !== 8'd254) begin bad++; $display("FAIL stat_254 got=%0d exp=254", carry_count); end
      end
    end
    sum_valid = 1'b0;
    total++; if (carry_count !== 8'd255) begin bad++; $display("FAIL stat_sat got=%0d exp=255", carry_count); end
    step();
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    total++; if (carry_count !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL stat_clear got=%0d/%0b exp=0/0", carry_count, overflow); end
    clear_stats = 1'b1; sum_in = 9'h133; sum_valid = 1'b1;
    step();
    clear_stats = 1'b0; sum_valid = 1'b0;
    total++; if (carry_count !== 8'd1) begin bad++; $display("FAIL stat_clr_push got=%0d exp=1", carry_count); end
    step();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sum_in = 9'h010 + 9'(i); sum_valid = 1'b1;
      step();
    end
    clear_stats = 1'b1; sum_in = 9'h0EE;
    step();
    clear_stats = 1'b0; sum_valid = 1'b0;
    total++; if (overflow !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL stat_clr_drop got=o%0b c%0d exp=o1 c4", overflow, count); end
    total++; if (carry_count !== 8'd0 || out_data !== 9'h011) begin bad++; $display("FAIL stat_clr_drop2 got=%0d/%h exp=0/011", carry_count, out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL pre_reset_count got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL async_rst got=v%0b c%0d e%0b o%0b exp=v0 c0 e1 o0", out_valid, count, empty, overflow); end
    #1 rst = 1'b0;
    sum_in = 9'h1C3; sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    total++; if (out_data !== 9'h1C3 || count !== 3'd1 || carry_count !== 8'd1) begin bad++; $display("FAIL post_rst got=%h c%0d k%0d exp=1c3 c1 k1", out_data, count, carry_count); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_full_push_pop();
    test_streaming();
    test_statistics();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_result_fifo.md
# adder_result_fifo

Downstream capture stage for the registered WIDTH-bit adder. It samples the adder's (WIDTH+1)-bit sum on a one-cycle strobe and buffers it in a DEPTH-entry first-word-fall-through FIFO. Results drain through a valid/ready output interface. It keeps a sticky overflow flag and a saturating count of sums that produced a carry-out (MSB set).

## Interface
- WIDTH, 8: adder operand width. Stored data width is WIDTH+1.
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sum_in  input  WIDTH+1  adder result.
- sum_valid  input  1  sum_in is to be captured this cycle.
- out_data  output  WIDTH+1  head-of-FIFO entry; meaningful only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; a sum was dropped.
- carry_count  output  8  accepted sums with sum_in[WIDTH]=1, saturating at 255.
- clear_stats  input  1  synchronous clear of overflow and carry_count.

## Operation
- Reset, asynchronous: rd/wr pointers=0, count=0, overflow=0, carry_count=0.
  - Resulting outputs: out_valid=0, empty=1, full=0, out_data=0.
  - Storage contents need not be cleared.
- pop = out_valid & out_ready.
- push = sum_valid & (!full | out_ready).
  - When full, a same-cycle pop frees a slot, so push is accepted.
- Drop = sum_valid & full & !out_ready.
  - Data is discarded and overflow is set on the next edge.
  - Pointers and count are unchanged.
- On push, write sum_in at wr_ptr, then wr_ptr+1 mod DEPTH. On pop, rd_ptr+1 mod DEPTH. Pointers wrap naturally.
- count changes by +1 (push only), −1 (pop only), or 0 (both or neither).
- pop while empty is impossible: out_valid gates it, and out_ready is ignored when empty.
- out_data = mem[rd_ptr] (FWFT).
  - out_data must not change while out_valid=1 and out_ready=0.
  - sum_valid activity while full must not disturb out_data.
- No empty bypass: a sum pushed into an empty FIFO is presented the cycle after capture.
- carry_count increments on each accepted push with sum_in[WIDTH]=1; it holds at 255.
  - Dropped sums do not count.
- clear_stats=1: overflow←0 and carry_count←0, except when the same cycle also has an event:
  - with a drop: overflow←1 (event wins);
  - with a counted push: carry_count←1.
- Arithmetic is unsigned. No data transformation; stored value equals sum_in bit-exact.

## Timing
- Capture latency: sum_valid at edge k → out_valid=1 and out_data=sum_in visible after edge k.
- Throughput: one push and one pop per cycle, sustained indefinitely when out_ready=1.
- count, full, empty, overflow and carry_count are registered and update on the same edge as the push/pop/drop.
- Reset mid-operation: all buffered data is lost immediately; outputs return to reset values asynchronously.
- First accepted push after rst deasserts is on the first clk edge with sum_valid=1.

## Test plan
- Reset then single capture: WIDTH=8, DEPTH=4.
  - Stimulus: sum_valid pulse with sum_in=9'h0FF, out_ready=0.
  - Response: next cycle out_valid=1, out_data=9'h0FF, count=1, carry_count=0.
  - Then out_ready=1 for one cycle → empty=1, count=0.
- Fill and overflow:
  - Stimulus: out_ready=0; push 9'h100, 9'h001, 9'h1FE, 9'h042; then push 9'h055.
  - Response after four pushes: full=1, count=4, carry_count=2.
  - Response after fifth push: overflow=1, count=4, 9'h055 never appears.
  - Drain with out_ready=1 → 100, 001, 1FE, 042 in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; sum_valid=1 with sum_in=9'h1AA, out_ready=1 in the same cycle.
  - Response: no overflow, count stays 4, head advances, 9'h1AA is last out.
- Streaming wrap-around:
  - Stimulus: 20 consecutive sums 0..19 with out_ready=1 every cycle.
  - Response: outputs 0..19 in order, each one cycle after capture; count ≤1; no overflow.
- Statistics:
  - Stimulus: 300 pushes with MSB=1 (draining continuously).
  - Response: carry_count=255.
  - clear_stats alone → carry_count=0, overflow=0.
  - clear_stats with counted push → carry_count=1.
  - clear_stats with drop → overflow=1.
- Async reset mid-stream:
  - Stimulus: rst asserted between edges with count=3.
  - Response: immediately out_valid=0, count=0, empty=1, overflow=0.
  - First post-reset push reads back correctly.
